// File: rtl/dds_pkg.sv
// Shared constants for the DDS Wishbone register block:
// word offsets, CTRL field layout, encodings and reset values.
package dds_pkg;

  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_TUNE  = 1;
  localparam int unsigned REG_OFFS  = 2;
  localparam int unsigned REG_CMT   = 3;
  localparam int unsigned REG_WAVE  = 4;
  localparam int unsigned REG_ID    = 5;
  localparam int unsigned REG_PKMAX = 6;
  localparam int unsigned REG_PKMIN = 7;

  localparam int unsigned EN_LSB   = 0;
  localparam int unsigned SRC_LSB  = 1;
  localparam int unsigned SRC_W    = 2;
  localparam int unsigned GAIN_LSB = 4;
  localparam int unsigned GAIN_W   = 2;

  typedef enum logic [1:0] {
    SRC_SINE = 2'b00,
    SRC_SAW  = 2'b01,
    SRC_TRI  = 2'b10,
    SRC_RAND = 2'b11
  } src_e;

  typedef enum logic [1:0] {
    GAIN_X1 = 2'b00,
    GAIN_X2 = 2'b01,
    GAIN_X4 = 2'b10,
    GAIN_X8 = 2'b11
  } gain_e;

  localparam logic [7:0] TUNE_RST = 8'd1;

endpackage

// File: rtl/dds_peak_track.sv
// Running max/min of the wave sample; outputs include the
// current sample so a re-armed tracker reads back live wave_i.
module dds_peak_track #(
  parameter int WAVE_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic [WAVE_WIDTH-1:0] wave_i,
  output logic [WAVE_WIDTH-1:0] max_o,
  output logic [WAVE_WIDTH-1:0] min_o
);

  logic [WAVE_WIDTH-1:0] max_q;
  logic [WAVE_WIDTH-1:0] min_q;

  assign max_o = (wave_i > max_q) ? wave_i : max_q;
  assign min_o = (wave_i < min_q) ? wave_i : min_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
      min_q <= '1;
    end else if (clr_i) begin
      max_q <= '0;
      min_q <= '1;
    end else begin
      max_q <= max_o;
      min_q <= min_o;
    end
  end

endmodule

// File: rtl/dds_wb_regs.sv
// Wishbone classic shadow/active control registers for the DDS core.
// Define DDS_WB_REGS_PEAK_EN to add PKMAX/PKMIN peak trackers.
module dds_wb_regs
  import dds_pkg::*;
#(
  parameter int          ADDR_W     = 4,
  parameter int          WAVE_WIDTH = 16,
  parameter logic [31:0] ID_VALUE   = 32'hDD5_0001
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  input  logic [WAVE_WIDTH-1:0] wave_i,
  output logic                  dds_en_o,
  output logic [1:0]            dds_src_o,
  output logic [1:0]            gain_word_o,
  output logic [7:0]            tuning_word_o,
  output logic [15:0]           offset_word_o,
  output logic                  update_o
);

  logic        ack_q, err_q, cmt_q, upd_q, pend_q, pend_d;
  logic [31:0] dat_q, rd_d;
  logic        sh_en_q, sh_en_d;
  logic [1:0]  sh_src_q, sh_src_d;
  logic [1:0]  sh_gain_q, sh_gain_d;
  logic [7:0]  sh_tune_q, sh_tune_d;
  logic [15:0] sh_offs_q, sh_offs_d;
  logic        en_q;
  logic [1:0]  src_q, gain_q;
  logic [7:0]  tune_q;
  logic [15:0] offs_q;

  logic req, wr, mapped, set_pend, cmt_d;
  logic h_ctrl, h_tune, h_offs, h_cmt;
  logic h_wave, h_id, h_max, h_min, h_pk;
  logic unused_bits;

  assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:2]};

  assign req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign h_ctrl = wb_adr_i == ADDR_W'(REG_CTRL);
  assign h_tune = wb_adr_i == ADDR_W'(REG_TUNE);
  assign h_offs = wb_adr_i == ADDR_W'(REG_OFFS);
  assign h_cmt  = wb_adr_i == ADDR_W'(REG_CMT);
  assign h_wave = wb_adr_i == ADDR_W'(REG_WAVE);
  assign h_id   = wb_adr_i == ADDR_W'(REG_ID);

`ifdef DDS_WB_REGS_PEAK_EN
  logic                  clr_q;
  logic [WAVE_WIDTH-1:0] pk_max, pk_min;

  assign h_max = wb_adr_i == ADDR_W'(REG_PKMAX);
  assign h_min = wb_adr_i == ADDR_W'(REG_PKMIN);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) clr_q <= 1'b0;
    else            clr_q <= wr & (h_max | h_min);
  end

  dds_peak_track #(
    .WAVE_WIDTH(WAVE_WIDTH)
  ) u_peak (
    .clk_i (wb_clk_i),
    .rst_ni(wb_rst_ni),
    .clr_i (clr_q),
    .wave_i(wave_i),
    .max_o (pk_max),
    .min_o (pk_min)
  );
`else
  logic [WAVE_WIDTH-1:0] pk_max, pk_min;

  assign h_max  = 1'b0;
  assign h_min  = 1'b0;
  assign pk_max = '0;
  assign pk_min = '0;
`endif

  assign h_pk   = h_max | h_min;
  assign mapped = h_ctrl | h_tune | h_offs | h_cmt
                | h_wave | h_id | h_pk;
  assign wr     = req & wb_we_i & mapped;

  assign set_pend = wr & (((h_ctrl | h_tune) & wb_sel_i[0])
                  | (h_offs & (|wb_sel_i[1:0])));
  assign cmt_d    = wr & h_cmt & wb_sel_i[0] & wb_dat_i[0];
  assign pend_d   = cmt_q ? 1'b0 : (pend_q | set_pend);

  always_comb begin
    sh_en_d   = sh_en_q;
    sh_src_d  = sh_src_q;
    sh_gain_d = sh_gain_q;
    sh_tune_d = sh_tune_q;
    sh_offs_d = sh_offs_q;
    if (wr & h_ctrl & wb_sel_i[0]) begin
      sh_en_d   = wb_dat_i[EN_LSB];
      sh_src_d  = wb_dat_i[SRC_LSB +: SRC_W];
      sh_gain_d = wb_dat_i[GAIN_LSB +: GAIN_W];
    end
    if (wr & h_tune & wb_sel_i[0]) sh_tune_d = wb_dat_i[7:0];
    if (wr & h_offs & wb_sel_i[0]) sh_offs_d[7:0] = wb_dat_i[7:0];
    if (wr & h_offs & wb_sel_i[1]) sh_offs_d[15:8] = wb_dat_i[15:8];
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      h_ctrl: begin
        rd_d[EN_LSB]             = sh_en_q;
        rd_d[SRC_LSB +: SRC_W]   = sh_src_q;
        rd_d[GAIN_LSB +: GAIN_W] = sh_gain_q;
      end
      h_tune:  rd_d[7:0]            = sh_tune_q;
      h_offs:  rd_d[15:0]           = sh_offs_q;
      h_cmt:   rd_d[0]              = pend_q;
      h_wave:  rd_d[WAVE_WIDTH-1:0] = wave_i;
      h_id:    rd_d                 = ID_VALUE;
      h_max:   rd_d[WAVE_WIDTH-1:0] = pk_max;
      h_min:   rd_d[WAVE_WIDTH-1:0] = pk_min;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      cmt_q     <= 1'b0;
      upd_q     <= 1'b0;
      pend_q    <= 1'b0;
      sh_en_q   <= 1'b0;
      sh_src_q  <= '0;
      sh_gain_q <= '0;
      sh_tune_q <= TUNE_RST;
      sh_offs_q <= '0;
      en_q      <= 1'b0;
      src_q     <= '0;
      gain_q    <= '0;
      tune_q    <= TUNE_RST;
      offs_q    <= '0;
    end else begin
      ack_q     <= req & mapped;
      err_q     <= req & ~mapped;
      dat_q     <= (req & ~wb_we_i & mapped) ? rd_d : '0;
      cmt_q     <= cmt_d;
      upd_q     <= cmt_q;
      pend_q    <= pend_d;
      sh_en_q   <= sh_en_d;
      sh_src_q  <= sh_src_d;
      sh_gain_q <= sh_gain_d;
      sh_tune_q <= sh_tune_d;
      sh_offs_q <= sh_offs_d;
      // commit lands one cycle after its ack
      if (cmt_q) begin
        en_q   <= sh_en_q;
        src_q  <= sh_src_q;
        gain_q <= sh_gain_q;
        tune_q <= sh_tune_q;
        offs_q <= sh_offs_q;
      end
    end
  end

  assign wb_dat_o      = dat_q;
  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign dds_en_o      = en_q;
  assign dds_src_o     = src_q;
  assign gain_word_o   = gain_q;
  assign tuning_word_o = tune_q;
  assign offset_word_o = offs_q;
  assign update_o      = upd_q;

endmodule
